// File: rtl/kernel_mem_writer_pkg.sv
// Shared types for the kernel memory write sequencer: complex sample, cacheline and FSM state.
// The optional KERNEL_MEM_WRITER_CHECK_EN build adds protocol error detection (see kernel_bank_status).
package kernel_mem_writer_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    // One cacheline carries 8 complex values; two of them make a 16-lane kernel word.
    typedef complex_t [0:1][0:3] cacheline_t;

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StFill   = 2'd1,
        StCommit = 2'd2
    } kmw_state_t;

    localparam int unsigned BANK_COUNT = 2;

    function automatic logic [BANK_COUNT-1:0] bank_mask(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/kernel_bank_status.sv
// Ping-pong ownership register for the two kernel banks, plus the optional protocol check.
// With KERNEL_MEM_WRITER_CHECK_EN defined, a release of a bank that is not ready sets a sticky err.
module kernel_bank_status
    import kernel_mem_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       commit,
    input  logic       commit_bank,
    input  logic [1:0] bank_release,
    output logic [1:0] bank_ready,
    output logic       err
);

    logic [1:0] ready_d;
    logic [1:0] set_mask;

    always_comb begin
        set_mask = commit ? bank_mask(commit_bank) : 2'b00;
        // Release and set are applied together so different banks both take effect.
        ready_d  = clear ? 2'b00 : ((bank_ready & ~bank_release) | set_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_ready <= 2'b00;
        end else begin
            bank_ready <= ready_d;
        end
    end

`ifdef KERNEL_MEM_WRITER_CHECK_EN
    logic err_d;

    always_comb begin
        err_d = clear ? 1'b0 : (err | (|(bank_release & ~bank_ready)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/kernel_mem_writer.sv
// Write-side sequencer for the double-buffered kernel memory: two cachelines per kernel word,
// bank ping-pong with the reader. err is only live when KERNEL_MEM_WRITER_CHECK_EN is defined.
module kernel_mem_writer
    import kernel_mem_writer_pkg::*;
#(
    parameter int unsigned KERNEL_MEM_DEPTH_BITS = 9,
    parameter int unsigned FILL_WORDS            = 512
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  cacheline_t                       in_data,
    output logic                             mem_we,
    output logic [KERNEL_MEM_DEPTH_BITS-1:0] mem_write_address,
    output logic                             mem_select_block_we,
    output logic                             mem_select_sub_block_we,
    output cacheline_t                       mem_in,
    output logic [1:0]                       bank_ready,
    input  logic [1:0]                       bank_release,
    output logic                             err
);

    localparam int unsigned CNT_W     = KERNEL_MEM_DEPTH_BITS + 1;
    localparam int unsigned LAST_WORD = FILL_WORDS - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = LAST_WORD[CNT_W-1:0];

    kmw_state_t       state_q;
    logic             wbank_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sub_q;
    logic             last_beat;
    logic             commit;

    assign in_ready  = (state_q == StFill) && !clear;
    assign last_beat = (cnt_q == LAST_CNT) && sub_q;
    assign commit    = (state_q == StCommit) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                 <= StWait;
            wbank_q                 <= 1'b0;
            cnt_q                   <= '0;
            sub_q                   <= 1'b0;
            mem_we                  <= 1'b0;
            mem_write_address       <= '0;
            mem_select_block_we     <= 1'b0;
            mem_select_sub_block_we <= 1'b0;
            mem_in                  <= '0;
        end else if (clear) begin
            state_q                 <= StWait;
            wbank_q                 <= 1'b0;
            cnt_q                   <= '0;
            sub_q                   <= 1'b0;
            mem_we                  <= 1'b0;
            mem_write_address       <= '0;
            mem_select_block_we     <= 1'b0;
            mem_select_sub_block_we <= 1'b0;
            mem_in                  <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state_q)
                StWait: begin
                    if (!bank_ready[wbank_q]) begin
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (in_valid) begin
                        mem_we                  <= 1'b1;
                        mem_in                  <= in_data;
                        mem_write_address       <= cnt_q[KERNEL_MEM_DEPTH_BITS-1:0];
                        mem_select_sub_block_we <= sub_q;
                        mem_select_block_we     <= wbank_q;
                        sub_q                   <= ~sub_q;
                        if (sub_q) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (last_beat) begin
                            state_q <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    // bank_ready is set by kernel_bank_status in this same cycle.
                    wbank_q <= ~wbank_q;
                    cnt_q   <= '0;
                    sub_q   <= 1'b0;
                    state_q <= StWait;
                end
                default: begin
                    state_q <= StWait;
                end
            endcase
        end
    end

    kernel_bank_status u_bank_status (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .commit       (commit),
        .commit_bank  (wbank_q),
        .bank_release (bank_release),
        .bank_ready   (bank_ready),
        .err          (err)
    );

endmodule

// File: tb/tb_kernel_mem_writer.sv
// Self-checking bench for kernel_mem_writer: table-driven first fill, directed corner sequences,
// random-gap fill checked by a beat-level write model. Honours KERNEL_MEM_WRITER_CHECK_EN.
module tb_kernel_mem_writer;
    import kernel_mem_writer_pkg::*;

    localparam int unsigned DB = 9;
    localparam int unsigned FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    cacheline_t    in_data = '0;
    logic          mem_we;
    logic [DB-1:0] mem_write_address;
    logic          mem_select_block_we;
    logic          mem_select_sub_block_we;
    cacheline_t    mem_in;
    logic [1:0]    bank_ready;
    logic [1:0]    bank_release = 2'b00;
    logic          err;

    kernel_mem_writer #(
        .KERNEL_MEM_DEPTH_BITS (DB),
        .FILL_WORDS            (FW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .clear                   (clear),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .mem_we                  (mem_we),
        .mem_write_address       (mem_write_address),
        .mem_select_block_we     (mem_select_block_we),
        .mem_select_sub_block_we (mem_select_sub_block_we),
        .mem_in                  (mem_in),
        .bank_ready              (bank_ready),
        .bank_release            (bank_release),
        .err                     (err)
    );

    always #5 clk = ~clk;

`ifdef KERNEL_MEM_WRITER_CHECK_EN
    localparam logic ERR_ON_SPURIOUS = 1'b1;
`else
    localparam logic ERR_ON_SPURIOUS = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic cacheline_t mk_line(input int k);
        cacheline_t l;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                l[i][j].re = 16'(k * 8 + i * 4 + j);
                l[i][j].im = 16'(k) ^ 16'hA5A5;
            end
        end
        return l;
    endfunction

    function automatic cacheline_t rnd_line();
        cacheline_t l;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                l[i][j] = complex_t'($urandom);
            end
        end
        return l;
    endfunction

    // Reference model: a fill is 2*FW beats; beat n goes to word n/2, half n%2 of the current bank.
    typedef struct packed {
        logic [DB-1:0] addr;
        logic          sub;
        logic          bank;
        cacheline_t    data;
    } wr_t;

    wr_t        exp_q[$];
    int         beat_n = 0;
    logic       m_bank = 1'b0;
    logic [1:0] m_ready = 2'b00;
    logic       m_err = 1'b0;
    logic       commit_pend = 1'b0;
    logic       commit_bank = 1'b0;

    always @(negedge clk) begin
        wr_t        w;
        logic [1:0] nxt;
        if (!rst_n) begin
            exp_q.delete();
            beat_n      = 0;
            m_bank      = 1'b0;
            m_ready     = 2'b00;
            m_err       = 1'b0;
            commit_pend = 1'b0;
        end else begin
            chk("model_bank_ready", bank_ready, m_ready);
            chk("model_err", err, m_err);
            if (mem_we) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got mem_we=1 addr %0d expected no write",
                             mem_write_address);
                end else begin
                    w = exp_q.pop_front();
                    chk("model_addr", mem_write_address, w.addr);
                    chk("model_sub", mem_select_sub_block_we, w.sub);
                    chk("model_bank", mem_select_block_we, w.bank);
                    chk("model_data", mem_in, w.data);
                end
            end
            if (clear) begin
                m_ready     = 2'b00;
                m_err       = 1'b0;
                beat_n      = 0;
                m_bank      = 1'b0;
                commit_pend = 1'b0;
            end else begin
                if (ERR_ON_SPURIOUS && ((bank_release & ~m_ready) != 2'b00)) m_err = 1'b1;
                nxt = m_ready & ~bank_release;
                if (commit_pend) nxt[commit_bank] = 1'b1;
                commit_pend = 1'b0;
                m_ready = nxt;
                if (in_valid && in_ready) begin
                    w.addr = DB'(beat_n / 2);
                    w.sub  = 1'(beat_n % 2);
                    w.bank = m_bank;
                    w.data = in_data;
                    exp_q.push_back(w);
                    beat_n++;
                    if (beat_n == 2 * FW) begin
                        commit_pend = 1'b1;
                        commit_bank = m_bank;
                        m_bank      = ~m_bank;
                        beat_n      = 0;
                    end
                end
            end
        end
    end

    task automatic beat(input cacheline_t d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int i;
        for (i = 0; i < budget && !in_ready; i++) cyc();
        chk("wait_in_ready", in_ready, 1'b1);
    endtask

    typedef struct {
        cacheline_t    d;
        logic [DB-1:0] addr;
        logic          sub;
        logic          blk;
    } vec_t;

    vec_t tbl[8];
    int unsigned addr_lit[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic        sub_lit[8]  = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int guard;
        for (int k = 0; k < 8; k++) begin
            tbl[k].d    = mk_line(k + 1);
            tbl[k].addr = DB'(addr_lit[k]);
            tbl[k].sub  = sub_lit[k];
            tbl[k].blk  = 1'b0;
        end

        repeat (3) cyc();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_addr", mem_write_address, 0);
        chk("rst_blk", mem_select_block_we, 1'b0);
        chk("rst_sub", mem_select_sub_block_we, 1'b0);
        chk("rst_mem_in", mem_in, 0);
        chk("rst_bank_ready", bank_ready, 2'b00);
        chk("rst_err", err, 1'b0);

        rst_n = 1'b1;
        cyc();
        chk("ready_after_reset", in_ready, 1'b1);

        // Back-to-back fill of bank 0 from the vector table.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = tbl[k].d;
            cyc();
            chk("tbl_we", mem_we, 1'b1);
            chk("tbl_addr", mem_write_address, tbl[k].addr);
            chk("tbl_sub", mem_select_sub_block_we, tbl[k].sub);
            chk("tbl_blk", mem_select_block_we, tbl[k].blk);
            chk("tbl_data", mem_in, tbl[k].d);
        end
        in_valid = 1'b0;
        chk("commit_in_ready", in_ready, 1'b0);
        chk("bank_ready_1cyc", bank_ready, 2'b00);
        cyc();
        chk("bank_ready_2cyc", bank_ready, 2'b01);
        chk("turn_in_ready", in_ready, 1'b0);
        chk("turn_mem_we", mem_we, 1'b0);
        cyc();
        chk("bank1_in_ready", in_ready, 1'b1);

        // Bank 1 with random 50% valid gaps; the model checks every write.
        acc = 0;
        guard = 0;
        while (acc < 8 && guard < 200) begin
            in_valid = 1'($urandom % 2);
            in_data  = rnd_line();
            #1;
            if (in_valid && in_ready) acc++;
            cyc();
            guard++;
        end
        in_valid = 1'b0;
        chk("rand_fill_beats", acc, 8);
        repeat (3) cyc();
        chk("both_ready", bank_ready, 2'b11);
        chk("owned_in_ready", in_ready, 1'b0);
        repeat (4) cyc();
        chk("owned_in_ready_held", in_ready, 1'b0);
        bank_release = 2'b01;
        #1;
        chk("release_cycle_in_ready", in_ready, 1'b0);
        cyc();
        bank_release = 2'b00;
        wait_ready(4);
        chk("after_release_ready", bank_ready, 2'b10);
        beat(mk_line(100));
        chk("refill_blk", mem_select_block_we, 1'b0);
        chk("refill_addr", mem_write_address, 0);
        chk("refill_sub", mem_select_sub_block_we, 1'b0);

        // Clear after beat 5 of the bank 0 refill.
        for (int k = 1; k < 5; k++) beat(mk_line(100 + k));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = mk_line(999);
        #1;
        chk("clear_in_ready", in_ready, 1'b0);
        cyc();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_bank_ready", bank_ready, 2'b00);
        chk("clear_mem_we", mem_we, 1'b0);
        chk("clear_addr", mem_write_address, 0);
        chk("clear_blk", mem_select_block_we, 1'b0);
        chk("clear_mem_in", mem_in, 0);
        wait_ready(4);
        beat(mk_line(200));
        chk("post_clear_addr", mem_write_address, 0);
        chk("post_clear_sub", mem_select_sub_block_we, 1'b0);
        chk("post_clear_blk", mem_select_block_we, 1'b0);

        // Asynchronous reset in the middle of a fill.
        beat(mk_line(201));
        beat(mk_line(202));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_we", mem_we, 1'b0);
        chk("arst_addr", mem_write_address, 0);
        chk("arst_sub", mem_select_sub_block_we, 1'b0);
        chk("arst_mem_in", mem_in, 0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_bank_ready", bank_ready, 2'b00);
        repeat (2) cyc();
        rst_n = 1'b1;
        wait_ready(4);
        beat(mk_line(300));
        chk("post_rst_we", mem_we, 1'b1);
        chk("post_rst_addr", mem_write_address, 0);
        chk("post_rst_blk", mem_select_block_we, 1'b0);
        chk("post_rst_sub", mem_select_sub_block_we, 1'b0);

        // Spurious release of bank 1 while nothing is ready.
        bank_release = 2'b10;
        cyc();
        bank_release = 2'b00;
        cyc();
        chk("spurious_err", err, ERR_ON_SPURIOUS);
        chk("spurious_bank_ready", bank_ready, 2'b00);
        repeat (3) cyc();
        chk("spurious_err_sticky", err, ERR_ON_SPURIOUS);

        repeat (2) cyc();
        chk("writes_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
